seq_step_controller: RTL and testbench

//  Sequencer feeding the seq/disable_dac inputs of the DAC signal composer.

---
 rtl/seq_ctrl_pkg.sv | 8 +
 rtl/seq_step_timer.sv | 20 ++
 rtl/seq_step_controller.sv | 98 +++++++++
 tb/tb_seq_step_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared state encoding and default widths for the step sequencer.
package seq_ctrl_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int STEP_W_DEF = 32;
    localparam int PER_W_DEF  = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/seq_step_timer.sv
// seq_step_timer: counts ticks within one table entry; tc marks the last tick of the entry.
module seq_step_timer #(
    parameter int STEP_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              tick,
    input  logic [STEP_W-1:0] len,
    output logic              tc
);
    logic [STEP_W-1:0] cnt;
    // a zero length behaves as one tick per entry
    assign tc = cnt == ((len == '0) ? '0 : len - 1'b1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (!run) cnt <= '0;
        else if (tick) cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/seq_step_controller.sv
// seq_step_controller: plays a LUT sequence with per-entry hold and period count, gating the DAC when idle.
module seq_step_controller
    import seq_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEP_W = STEP_W_DEF,
    parameter int PER_W  = PER_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              tick,
    input  logic [STEP_W-1:0] step_len,
    input  logic [ADDR_W:0]   seq_len,
    input  logic [PER_W-1:0]  num_periods,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] seq_out,
    output logic              disable_dac,
    output logic              running,
    output logic              done,
    output logic [ADDR_W-1:0] step_idx,
    output logic [PER_W-1:0]  period_cnt
);
    state_t state, state_nx;
    logic [STEP_W-1:0] len_q;
    logic [ADDR_W:0]   seq_q;
    logic [PER_W-1:0]  per_q;
    logic [ADDR_W-1:0] nxt;
    logic tc, go, step, wrap, finish;

    seq_step_timer #(.STEP_W(STEP_W)) u_timer (
        .clk (clk),
        .rst (rst),
        .run (state == RUN),
        .tick(tick),
        .len (len_q),
        .tc  (tc)
    );

    assign nxt    = ({1'b0, step_idx} == seq_q - 1'b1) ? '0 : step_idx + 1'b1;
    assign wrap   = nxt == '0;
    assign go     = state == IDLE && start && !stop && seq_len != '0;
    assign step   = state == RUN && !stop && tick && tc;
    // the final boundary ends the run without presenting entry 0 again
    assign finish = step && wrap && per_q != '0 && period_cnt + 1'b1 == per_q;
    assign mem_addr = (state == RUN) ? nxt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? RUN : IDLE;
            RUN:     state_nx = stop ? IDLE : finish ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            seq_q       <= '0;
            per_q       <= '0;
            seq_out     <= '0;
            disable_dac <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            step_idx    <= '0;
            period_cnt  <= '0;
        end else begin
            done <= finish;
            if (go) begin
                len_q       <= step_len;
                seq_q       <= seq_len;
                per_q       <= num_periods;
                seq_out     <= mem_data;
                disable_dac <= 1'b0;
                running     <= 1'b1;
                step_idx    <= '0;
                period_cnt  <= '0;
            end else if (state == RUN && (stop || finish)) begin
                seq_out     <= '0;
                disable_dac <= 1'b1;
                running     <= 1'b0;
            end else if (step) begin
                step_idx <= nxt;
                seq_out  <= mem_data;
                if (wrap) period_cnt <= period_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_step_controller.sv
// tb_seq_step_controller: randomized and directed runs checked against a tick-count reference model via a scoreboard.
module tb_seq_step_controller;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0, stop = 0, tick = 0;
    logic [31:0] step_len = 0;
    logic [10:0] seq_len = 0;
    logic [15:0] num_periods = 0;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] seq_out;
    logic        disable_dac, running, done;
    logic [9:0]  step_idx;
    logic [15:0] period_cnt;
    logic [15:0] lut [0:1023];

    typedef struct packed {
        logic [15:0] seq;
        logic        dis;
        logic        run;
        logic        dn;
        logic [9:0]  idx;
        logic [15:0] per;
        logic        chk;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0, n_bad = 0;
    int m_st = 0, k = 0, eff = 1, ml = 1, mp = 0;
    logic [31:0] nx_step = 0;
    logic [10:0] nx_seq = 0;
    logic [15:0] nx_per = 0;

    always #5 clk = ~clk;
    assign mem_data = lut[mem_addr];

    seq_step_controller dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .tick(tick),
        .step_len(step_len), .seq_len(seq_len), .num_periods(num_periods),
        .mem_addr(mem_addr), .mem_data(mem_data), .seq_out(seq_out),
        .disable_dac(disable_dac), .running(running), .done(done),
        .step_idx(step_idx), .period_cnt(period_cnt)
    );

    // Reference: outputs follow from the tick count k since start; entry = k/eff.
    function automatic exp_t model_out();
        exp_t e;
        int n;
        e = '0;
        e.dis = 1'b1;
        if (m_st == 1) begin
            n     = k / eff;
            e.idx = 10'(n % ml);
            e.per = 16'(n / ml);
            e.seq = lut[n % ml];
            e.dis = 1'b0;
            e.run = 1'b1;
            e.chk = 1'b1;
        end else if (m_st == 2) begin
            e.dn = 1'b1;
        end
        return e;
    endfunction

    task automatic cyc(input bit s, input bit p, input bit t);
        @(negedge clk);
        #1;
        rst = 0; start = s; stop = p; tick = t;
        step_len = nx_step; seq_len = nx_seq; num_periods = nx_per;
        case (m_st)
            0: if (s && !p && nx_seq != 0) begin
                eff = (nx_step == 0) ? 1 : int'(nx_step);
                ml = int'(nx_seq); mp = int'(nx_per); k = 0; m_st = 1;
            end
            1: if (p) m_st = 0;
               else if (t) begin
                   k++;
                   if (mp != 0 && k / eff == ml * mp) m_st = 2;
               end
            default: m_st = 0;
        endcase
        q.push_back(model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1;
        #1;
        n_cmp++;
        if (seq_out !== 0 || disable_dac !== 1 || running !== 0 || done !== 0 ||
            step_idx !== 0 || period_cnt !== 0 || mem_addr !== 0) begin
            n_bad++;
            $display("FAIL async_reset: got seq=%0d dis=%0b run=%0b done=%0b idx=%0d per=%0d addr=%0d exp all zero, dis=1",
                     $signed(seq_out), disable_dac, running, done, step_idx, period_cnt, mem_addr);
        end
        q.delete();
        m_st = 0;
        q.push_back(model_out());
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (seq_out !== e.seq || disable_dac !== e.dis || running !== e.run || done !== e.dn ||
                (e.chk && (step_idx !== e.idx || period_cnt !== e.per))) begin
                n_bad++;
                $display("FAIL outputs @%0t: got seq=%0d dis=%0b run=%0b done=%0b idx=%0d per=%0d exp seq=%0d dis=%0b run=%0b done=%0b idx=%0d per=%0d",
                         $time, $signed(seq_out), disable_dac, running, done, step_idx, period_cnt,
                         $signed(e.seq), e.dis, e.run, e.dn, e.idx, e.per);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) lut[i] = 16'(i * 7 + 1);
        lut[0] = 16'sd100; lut[1] = -16'sd200; lut[2] = 16'sd300;
        do_reset();
        repeat (2) cyc(0, 0, 1);
        // table of three, two ticks each, two periods
        nx_step = 2; nx_seq = 3; nx_per = 2;
        cyc(1, 0, 1);
        repeat (16) cyc(0, 0, 1);
        // zero step length acts as one
        nx_step = 0; nx_seq = 4; nx_per = 1;
        cyc(1, 0, 1);
        repeat (7) cyc(0, 0, 1);
        // sparse ticks
        nx_step = 1; nx_seq = 3; nx_per = 2;
        cyc(1, 0, 0);
        for (int i = 1; i < 24; i++) cyc(0, 0, i % 3 == 0);
        // endless run, stop, then start+stop together
        nx_step = 1; nx_seq = 5; nx_per = 0;
        cyc(1, 0, 1);
        repeat (10) cyc(0, 0, 1);
        cyc(0, 1, 1);
        repeat (3) cyc(0, 0, 1);
        cyc(1, 1, 1);
        repeat (3) cyc(0, 0, 1);
        // config change mid-run is ignored, restart picks it up
        nx_step = 2; nx_seq = 3; nx_per = 0;
        cyc(1, 0, 1);
        repeat (3) cyc(0, 0, 1);
        nx_step = 5;
        repeat (8) cyc(0, 0, 1);
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        cyc(1, 0, 1);
        repeat (12) cyc(0, 0, 1);
        cyc(0, 1, 0);
        nx_seq = 0;
        cyc(1, 0, 1);
        repeat (3) cyc(0, 0, 1);
        // seq_len of one: every boundary wraps
        nx_step = 1; nx_seq = 1; nx_per = 3;
        cyc(1, 0, 1);
        repeat (6) cyc(0, 0, 1);
        // reset in the middle of a run, then a fresh start
        nx_step = 2; nx_seq = 4; nx_per = 0;
        cyc(1, 0, 1);
        repeat (5) cyc(0, 0, 1);
        do_reset();
        cyc(0, 0, 1);
        cyc(1, 0, 1);
        repeat (6) cyc(0, 0, 1);
        // randomized traffic
        do_reset();
        for (int i = 0; i < 1024; i++) lut[i] = 16'($urandom);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                nx_step = $urandom_range(0, 3);
                nx_seq  = 11'($urandom_range(0, 6));
                nx_per  = 16'($urandom_range(0, 3));
            end
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                (i & 256) != 0 || $urandom_range(0, 1) == 1);
        end
        repeat (3) cyc(0, 0, 0);
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
